// File: rtl/lda_pkg.sv
// Shared widths, screen bounds, FSM encoding and small arithmetic helpers
// for the Bresenham line-draw engine.
package lda_pkg;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COL_W    = 3;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  // Signed working width for coordinates/deltas, and for the error term.
  localparam int AW = 10;
  localparam int EW = 11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_INIT  = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic signed [AW-1:0] abs_s(input logic signed [AW-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/lda_octant_setup.sv
// Combinational octant normalisation: detect a steep line, transpose it,
// then order the endpoints so the major axis always runs left to right.
module lda_octant_setup
  import lda_pkg::*;
(
  input  logic [X_W-1:0]        x0,
  input  logic [Y_W-1:0]        y0,
  input  logic [X_W-1:0]        x1,
  input  logic [Y_W-1:0]        y1,
  output logic                  steep,
  output logic signed [AW-1:0]  sx0,
  output logic signed [AW-1:0]  sy0,
  output logic signed [AW-1:0]  sx1,
  output logic signed [AW-1:0]  sy1
);

  logic signed [AW-1:0] ax0, ay0, ax1, ay1;
  logic signed [AW-1:0] adx, ady;
  logic signed [AW-1:0] px0, py0, px1, py1;

  assign ax0 = AW'(x0);
  assign ay0 = AW'(y0);
  assign ax1 = AW'(x1);
  assign ay1 = AW'(y1);

  assign adx = abs_s(ax1 - ax0);
  assign ady = abs_s(ay1 - ay0);

  always_comb begin
    steep = (ady > adx);
    px0   = steep ? ay0 : ax0;
    py0   = steep ? ax0 : ay0;
    px1   = steep ? ay1 : ax1;
    py1   = steep ? ax1 : ay1;
    sx0   = px0;
    sy0   = py0;
    sx1   = px1;
    sy1   = py1;
    if (px0 > px1) begin
      sx0 = px1;
      sy0 = py1;
      sx1 = px0;
      sy1 = py0;
    end
  end

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line engine: latches a line request, normalises the octant,
// then emits one pixel per accepted cycle with sink back-pressure and clipping.
module line_draw_engine
  import lda_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y1,
  input  logic [COL_W-1:0]  colour,
  output logic              ready,
  output logic              done,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [COL_W-1:0]  vga_colour,
  output logic              vga_plot,
  input  logic              pix_ready
);

  localparam logic signed [AW-1:0] SCR_W_S = AW'(SCREEN_W);
  localparam logic signed [AW-1:0] SCR_H_S = AW'(SCREEN_H);

  logic [2:0]             state_reg;
  logic [X_W-1:0]         x0_reg, x1_reg;
  logic [Y_W-1:0]         y0_reg, y1_reg;
  logic [COL_W-1:0]       colour_reg;

  logic                   steep_reg;
  logic signed [AW-1:0]   sx0_reg, sy0_reg, sx1_reg, sy1_reg;

  logic signed [AW-1:0]   dx_reg, dy_reg, ystep_reg, cx_reg, cy_reg;
  logic signed [EW-1:0]   err_reg;

  logic                   oct_steep;
  logic signed [AW-1:0]   oct_x0, oct_y0, oct_x1, oct_y1;

  logic signed [AW-1:0]   init_dx, init_dy;
  logic signed [EW-1:0]   init_err;
  logic signed [EW-1:0]   err_sub, err_next;
  logic signed [AW-1:0]   cx_next, cy_next;
  logic signed [AW-1:0]   px, py;
  logic                   in_draw, on_screen, accept;

  lda_octant_setup u_octant (
    .x0    (x0_reg),
    .y0    (y0_reg),
    .x1    (x1_reg),
    .y1    (y1_reg),
    .steep (oct_steep),
    .sx0   (oct_x0),
    .sy0   (oct_y0),
    .sx1   (oct_x1),
    .sy1   (oct_y1)
  );

  assign init_dx  = sx1_reg - sx0_reg;
  assign init_dy  = abs_s(sy1_reg - sy0_reg);
  assign init_err = EW'(init_dx) >>> 1;

  always_comb begin
    err_sub  = err_reg - EW'(dy_reg);
    err_next = err_sub;
    cy_next  = cy_reg;
    cx_next  = cx_reg + AW'(1);
    if (err_sub < 0) begin
      err_next = err_sub + EW'(dx_reg);
      cy_next  = cy_reg + ystep_reg;
    end
  end

  // Undo the steep transpose when presenting the current point.
  assign px        = steep_reg ? cy_reg : cx_reg;
  assign py        = steep_reg ? cx_reg : cy_reg;
  assign in_draw   = (state_reg == ST_DRAW);
  assign on_screen = (px >= 0) && (px < SCR_W_S) && (py >= 0) && (py < SCR_H_S);
  assign accept    = in_draw && (!on_screen || pix_ready);

  assign ready      = (state_reg == ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign vga_plot   = in_draw && on_screen;
  assign vga_x      = in_draw ? px[X_W-1:0] : '0;
  assign vga_y      = in_draw ? py[Y_W-1:0] : '0;
  assign vga_colour = in_draw ? colour_reg : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      x0_reg     <= '0;
      y0_reg     <= '0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      colour_reg <= '0;
      steep_reg  <= 1'b0;
      sx0_reg    <= '0;
      sy0_reg    <= '0;
      sx1_reg    <= '0;
      sy1_reg    <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      ystep_reg  <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      err_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            x0_reg     <= x0;
            y0_reg     <= y0;
            x1_reg     <= x1;
            y1_reg     <= y1;
            colour_reg <= colour;
            state_reg  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          steep_reg <= oct_steep;
          sx0_reg   <= oct_x0;
          sy0_reg   <= oct_y0;
          sx1_reg   <= oct_x1;
          sy1_reg   <= oct_y1;
          state_reg <= ST_INIT;
        end
        ST_INIT: begin
          dx_reg    <= init_dx;
          dy_reg    <= init_dy;
          err_reg   <= init_err;
          ystep_reg <= (sy0_reg < sy1_reg) ? AW'(1) : '1;
          cx_reg    <= sx0_reg;
          cy_reg    <= sy0_reg;
          state_reg <= ST_DRAW;
        end
        ST_DRAW: begin
          if (accept) begin
            if (cx_reg == sx1_reg) begin
              state_reg <= ST_DONE;
            end else begin
              cx_reg  <= cx_next;
              cy_reg  <= cy_next;
              err_reg <= err_next;
            end
          end
        end
        ST_DONE: begin
          if (!start) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed and randomised line requests checked against a closed-form
// Bresenham reference (pixel list computed from the y-step count formula).
module tb_line_draw_engine;
  import lda_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, pix_ready;
  logic [X_W-1:0]    x0, x1;
  logic [Y_W-1:0]    y0, y1;
  logic [COL_W-1:0]  colour;
  logic              ready, done, vga_plot;
  logic [X_W-1:0]    vga_x;
  logic [Y_W-1:0]    vga_y;
  logic [COL_W-1:0]  vga_colour;

  int vectors = 0;
  int miscompares = 0;
  int ex[$];
  int ey[$];
  bit eon[$];

  line_draw_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .colour     (colour),
    .ready      (ready),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .pix_ready  (pix_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Point i along the major axis has taken k = ceil((i*dy - dx/2)/dx) minor steps.
  task automatic build_model(input int a0, input int b0, input int a1, input int b1);
    int ux0, uy0, ux1, uy1, t, dx, dy, ys, e0, k, cx, cy, px, py;
    bit steep;
    ex.delete(); ey.delete(); eon.delete();
    steep = ((b1 > b0 ? b1 - b0 : b0 - b1) > (a1 > a0 ? a1 - a0 : a0 - a1));
    ux0 = steep ? b0 : a0;  uy0 = steep ? a0 : b0;
    ux1 = steep ? b1 : a1;  uy1 = steep ? a1 : b1;
    if (ux0 > ux1) begin
      t = ux0; ux0 = ux1; ux1 = t;
      t = uy0; uy0 = uy1; uy1 = t;
    end
    dx = ux1 - ux0;
    dy = (uy1 > uy0) ? uy1 - uy0 : uy0 - uy1;
    ys = (uy0 < uy1) ? 1 : -1;
    e0 = dx / 2;
    for (int i = 0; i <= dx; i++) begin
      k  = (i * dy > e0) ? (i * dy - e0 + dx - 1) / dx : 0;
      cx = ux0 + i;
      cy = uy0 + ys * k;
      px = steep ? cy : cx;
      py = steep ? cx : cy;
      ex.push_back(px);
      ey.push_back(py);
      eon.push_back(px >= 0 && px < SCREEN_W && py >= 0 && py < SCREEN_H);
    end
  endtask

  // Starts at a negedge with the engine idle; returns at a negedge with it idle again.
  task automatic run_line(input int a0, input int b0, input int a1, input int b1, input int col,
                          input int stall_at, input int stall_len, input int hold, input bit pulse);
    int n, c, s, stalled, i;
    bit fin;
    build_model(a0, b0, a1, b1);
    n = ex.size();
    chk("idle_ready", 32'(ready), 1);
    chk("idle_done", 32'(done), 0);
    x0 = a0[X_W-1:0]; y0 = b0[Y_W-1:0];
    x1 = a1[X_W-1:0]; y1 = b1[Y_W-1:0];
    colour = col[COL_W-1:0];
    start = 1'b1;
    pix_ready = 1'b1;
    c = 0; s = 0; stalled = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        x0 = X_W'($urandom); y0 = Y_W'($urandom);
        x1 = X_W'($urandom); y1 = Y_W'($urandom);
        colour = COL_W'($urandom);
        if (pulse) start = 1'b0;
      end
      i = c - 3 - s;
      if (c > n + stall_len + 8) begin
        chk("timeout_cycle", 32'(c), 32'(n + 3 + s));
        fin = 1'b1;
      end else if (c < 3) begin
        chk("busy_ready", 32'(ready), 0);
        chk("busy_plot", 32'(vga_plot), 0);
      end else if (i < n) begin
        pix_ready = !(i == stall_at && stalled < stall_len);
        chk("plot", 32'(vga_plot), 32'(eon[i]));
        chk("draw_done", 32'(done), 0);
        if (eon[i]) begin
          chk("pix_x", 32'(vga_x), 32'(ex[i]));
          chk("pix_y", 32'(vga_y), 32'(ey[i]));
          chk("pix_col", 32'(vga_colour), 32'(col));
        end
        if (vga_plot && !pix_ready) begin
          stalled++;
          s++;
        end
      end else begin
        pix_ready = 1'b1;
        chk("done_cycle", 32'(done), 1);
        chk("done_ready", 32'(ready), 0);
        chk("done_plot", 32'(vga_plot), 0);
        fin = 1'b1;
      end
    end
    if (!pulse) begin
      repeat (hold) begin
        @(negedge clk);
        chk("done_hold", 32'(done), 1);
      end
      start = 1'b0;
    end
    @(negedge clk);
    chk("back_idle_ready", 32'(ready), 1);
    chk("back_idle_done", 32'(done), 0);
    $display("line (%0d,%0d)->(%0d,%0d) col %0d: %0d points, %0d stall cycles, total checks %0d",
             a0, b0, a1, b1, col, n, s, vectors);
  endtask

  initial begin
    int ra0, rb0, ra1, rb1, lim;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_x", 32'(vga_x), 0);
    chk("rst_y", 32'(vga_y), 0);
    chk("rst_col", 32'(vga_colour), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_line(10, 20, 14, 20, 5, -1, 0, 0, 1'b0);      // horizontal
    run_line(50, 100, 48, 94, 3, -1, 0, 0, 1'b0);     // steep, reversed
    run_line(0, 0, 3, 3, 6, 1, 2, 0, 1'b0);           // back-pressure on 2nd pixel
    run_line(318, 10, 322, 10, 2, -1, 0, 0, 1'b0);    // right-edge clipping
    run_line(7, 7, 7, 7, 1, -1, 0, 0, 1'b0);          // single point
    run_line(30, 5, 30, 12, 4, -1, 0, 4, 1'b0);       // vertical, done held 4 cycles
    run_line(20, 200, 25, 250, 7, -1, 0, 0, 1'b1);    // pulse start, bottom clipping

    // Reset part way through a long line.
    x0 = 9'd0; y0 = 8'd0; x1 = 9'd100; y1 = 8'd0; colour = 3'd6;
    start = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_plot", 32'(vga_plot), 1);
    chk("pre_rst_x", 32'(vga_x), 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_plot", 32'(vga_plot), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_x", 32'(vga_x), 0);
    chk("mid_rst_col", 32'(vga_colour), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_plot", 32'(vga_plot), 0);
    run_line(5, 5, 9, 2, 2, -1, 0, 0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      lim = (k % 2 == 0) ? 40 : 511;
      ra0 = $urandom_range(0, lim);
      ra1 = $urandom_range(0, lim);
      rb0 = $urandom_range(0, (lim > 255) ? 255 : lim);
      rb1 = $urandom_range(0, (lim > 255) ? 255 : lim);
      run_line(ra0, rb0, ra1, rb1, $urandom_range(0, 7), $urandom_range(0, 8),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_draw_engine.md
Name: line_draw_engine

Overview:
- Bresenham line-drawing datapath that sits directly downstream of the Avalon slave controller.
- Consumes its start, x0/y0/x1/y1 and colour outputs, and returns ready/done to it.
- Emits one pixel per accepted cycle toward the VGA pixel writer (x, y, colour, plot with back-pressure).
- Handles all octants via steep-swap and endpoint swap; clips off-screen pixels.

Parameters:
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
COL_W, 3, colour width
SCREEN_W, 320, pixels with x >= SCREEN_W are not plotted
SCREEN_H, 240, pixels with y >= SCREEN_H are not plotted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  draw request, level; held by controller until done seen (stall mode) or 1-cycle pulse (poll mode)
x0  in  X_W  start x
y0  in  Y_W  start y
x1  in  X_W  end x
y1  in  Y_W  end y
colour  in  COL_W  line colour
ready  out  1  engine idle, will accept start
done  out  1  line complete; held until start low
vga_x  out  X_W  pixel x
vga_y  out  Y_W  pixel y
vga_colour  out  COL_W  pixel colour
vga_plot  out  1  pixel valid
pix_ready  in  1  sink accepts pixel this cycle when vga_plot high

Behaviour:
- Reset (async, active-high): state IDLE; ready=1; done=0; vga_plot=0; vga_x=0; vga_y=0; vga_colour=0; all internal registers 0. Reset mid-line abandons the line; no further plot.
- States: IDLE -> SETUP -> INIT -> DRAW -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On start=1, latch x0,y0,x1,y1,colour and go to SETUP.
  - Input changes after the latch are ignored until the return to IDLE.
- SETUP, 1 cycle:
  - steep = |y1-y0| > |x1-x0|; if steep, swap x<->y of both endpoints.
  - If the (post-swap) x0 > x1, swap the endpoints.
  - All arithmetic is 10-bit signed.
- INIT, 1 cycle:
  - dx = x1-x0 (>= 0); dy = |y1-y0|.
  - err = dx >>> 1 (11-bit signed).
  - ystep = +1 if y0 < y1, else -1.
  - Current point (cx, cy) = (x0, y0).
- DRAW:
  - Present pixel (steep ? cy : cx, steep ? cx : cy) with the latched colour.
  - vga_plot=1 only if the pixel is on screen. When vga_plot=0 (off-screen), it counts as accepted.
  - Accepted when vga_plot&&pix_ready or vga_plot=0. While vga_plot&&!pix_ready, hold vga_x/vga_y/vga_colour/vga_plot stable and freeze the state.
  - On accept, if cx == x1 go to DONE. Otherwise:
    - cx += 1; err -= dy;
    - if the new err < 0: cy += ystep, err += dx.
- DONE:
  - done=1, vga_plot=0, ready=0.
  - Remains while start=1; goes to IDLE on the first cycle start=0, so done lasts at least 1 cycle.
  - A start that is high on entry to IDLE from DONE is impossible by construction.
- Latency with pix_ready=1:
  - start sampled in cycle 0; SETUP in cycle 1; INIT in cycle 2.
  - The first pixel is driven in cycle 3; an N-pixel line (N = dx+1) occupies cycles 3..N+2.
  - done first high in cycle N+3.
- Degenerate cases:
  - x0==x1 && y0==y1: exactly 1 pixel.
  - Vertical line: steep, dy+1 pixels.
  - Horizontal line: dx+1 pixels.
- Every line plots exactly max(|dx|,|dy|)+1 points, counting clipped points. Endpoints are always included.
- ready=0 in SETUP/INIT/DRAW/DONE; a start arriving in those states is ignored.

Decomposition:
- Package lda_pkg holds:
  - widths X_W/Y_W/COL_W;
  - SCREEN_W/SCREEN_H;
  - the state enum (IDLE, SETUP, INIT, DRAW, DONE);
  - the signed arithmetic width constant (10) and error width (11).
- One sub-module, lda_octant_setup: combinational steep detection and endpoint swapping, feeding the SETUP register stage. Everything else stays in line_draw_engine.

Test Plan:
- Horizontal: (10,20)->(14,20), colour 5, pix_ready=1 -> pixels x=10..14 at y=20, colour 5, first plot cycle 3, done high cycle 8, ready back 1 cycle after start drops.
- Steep reversed: (50,100)->(48,94) -> 7 pixels (48,94),(48,95),(49,96),(49,97),(49,98),(50,99),(50,100), one per cycle.
- Back-pressure: (0,0)->(3,3) with pix_ready low for 2 cycles on the 2nd pixel -> (1,1) held stable 3 cycles, sequence (0,0),(1,1),(2,2),(3,3), nothing dropped or duplicated.
- Clipping and point: (318,10)->(322,10) -> vga_plot only for x=318,319, done after 5 step cycles; (7,7)->(7,7) -> exactly one pixel.
- Done handshake: start held high 4 cycles past completion -> done high for all 4 plus the completion cycle, IDLE the cycle after start falls; a 1-cycle start pulse -> done is a 1-cycle pulse.
- Reset mid-line: reset asserted during DRAW of (0,0)->(100,0) -> vga_plot, done and vga outputs 0 immediately (async), ready=1; the next start draws a fresh line correctly.
